// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 key controller.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } ps2_state_t;

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder sitting behind the ps2_keyboard FIFO: pops one byte at a time
// and turns E0/F0 prefixed sequences into key events. Option: PS2_TYPEMATIC_FILTER_EN.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             evt_valid,
    output logic             evt_break,
    output logic [CNT_W-1:0] press_count,
    output logic             err
);

    ps2_state_t state;
    logic [7:0] byte_buf;
    logic       ext_pending;
    logic       brk_pending;
    logic       repeat_make;

    // A held key re-sends its make code; optionally swallow those repeats.
    always_comb begin
        repeat_make = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        repeat_make = key_down && !brk_pending &&
                      (byte_buf == key_code) && (ext_pending == key_ext);
`endif
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            byte_buf    <= 8'h00;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            nextdata_n  <= 1'b1;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_down    <= 1'b0;
            evt_valid   <= 1'b0;
            evt_break   <= 1'b0;
            press_count <= '0;
            err         <= 1'b0;
        end else begin
            evt_valid  <= 1'b0;
            nextdata_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_buf   <= data;
                        nextdata_n <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: begin
                    state <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    if (byte_buf == PS2_EXT_CODE) begin
                        ext_pending <= 1'b1;
                    end else if (byte_buf == PS2_BRK_CODE) begin
                        brk_pending <= 1'b1;
                    end else begin
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                        if (!repeat_make) begin
                            evt_valid <= 1'b1;
                            key_code  <= byte_buf;
                            key_ext   <= ext_pending;
                            evt_break <= brk_pending;
                            if (brk_pending) begin
                                key_down <= 1'b0;
                            end else begin
                                key_down    <= 1'b1;
                                press_count <= press_count + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Placed last so a lost byte discards any prefix decoded on the same edge.
            if (overflow) begin
                err         <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a behavioural model of the ps2_keyboard FIFO.
module tb_ps2_key_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             ready = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             overflow = 1'b0;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic             evt_valid;
    logic             evt_break;
    logic [CNT_W-1:0] press_count;
    logic             err;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       down;
    } ev_t;

    logic [7:0] fifo[$];
    ev_t        evq[$];
    int         pops = 0;
    int         bad_pops = 0;
    int         long_pulses = 0;
    logic       prev_low = 1'b0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         e0;
    int         p0;
    ev_t        ev;

    ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ready       (ready),
        .data        (data),
        .overflow    (overflow),
        .nextdata_n  (nextdata_n),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_down    (key_down),
        .evt_valid   (evt_valid),
        .evt_break   (evt_break),
        .press_count (press_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic upd();
        ready = (fifo.size() > 0);
        data  = ready ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd();
    endtask

    // One clock: observe at the falling edge, apply the FIFO pop just after the rising edge.
    task automatic tick();
        logic pop_now;
        ev_t  e;
        pop_now = 1'b0;
        @(negedge clk);
        if (!nextdata_n) begin
            pops++;
            pop_now = 1'b1;
            if (!ready) bad_pops++;
            if (prev_low) long_pulses++;
        end
        prev_low = !nextdata_n;
        if (evt_valid) begin
            e.code = key_code;
            e.ext  = key_ext;
            e.brk  = evt_break;
            e.down = key_down;
            evq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        upd();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 4000) begin
            tick();
            n++;
        end
        check("drain_timeout", fifo.size(), 0);
        repeat (5) tick();
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        overflow = 1'b0;
        fifo.delete();
        upd();
        repeat (2) tick();
        clrn = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values while clrn is held low
        tick();
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_code", key_code, 8'h00);
        check("rst_key_ext", key_ext, 0);
        check("rst_key_down", key_down, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_break", evt_break, 0);
        check("rst_press_count", press_count, 0);
        check("rst_err", err, 0);

        // Single make code
        do_reset();
        e0 = evq.size(); p0 = pops;
        push(8'h1C);
        drain();
        check("make_evts", evq.size() - e0, 1);
        ev = evq[evq.size()-1];
        check("make_code", ev.code, 8'h1C);
        check("make_brk", ev.brk, 0);
        check("make_ext", ev.ext, 0);
        check("make_down", key_down, 1);
        check("make_count", press_count, 1);
        check("make_pops", pops - p0, 1);

        // Make then break
        do_reset();
        e0 = evq.size(); p0 = pops;
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        check("mb_evts", evq.size() - e0, 2);
        check("mb_brk0", evq[e0].brk, 0);
        check("mb_brk1", evq[e0+1].brk, 1);
        check("mb_down", key_down, 0);
        check("mb_count", press_count, 1);
        check("mb_pops", pops - p0, 3);

        // Extended make and break
        do_reset();
        e0 = evq.size();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        check("ext_evts", evq.size() - e0, 2);
        check("ext_ev0", {evq[e0].code, evq[e0].ext, evq[e0].brk}, {8'h75, 1'b1, 1'b0});
        check("ext_ev1", {evq[e0+1].code, evq[e0+1].ext, evq[e0+1].brk}, {8'h75, 1'b1, 1'b1});
        check("ext_count", press_count, 1);

        // F0 before E0 still gives an extended break
        do_reset();
        e0 = evq.size();
        push(8'hF0); push(8'hE0); push(8'h6B);
        drain();
        check("fe_evts", evq.size() - e0, 1);
        check("fe_ev", {evq[e0].code, evq[e0].ext, evq[e0].brk}, {8'h6B, 1'b1, 1'b1});

        // Typematic repeats
        do_reset();
        e0 = evq.size();
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("rep_evts", evq.size() - e0, 1);
        check("rep_count", press_count, 1);
`else
        check("rep_evts", evq.size() - e0, 3);
        check("rep_count", press_count, 3);
`endif

        // 256 make/break pairs wrap the counter
        do_reset();
        e0 = evq.size(); p0 = pops;
        for (int i = 0; i < 256; i++) begin
            push(8'h1C); push(8'hF0); push(8'h1C);
        end
        drain();
        check("wrap_evts", evq.size() - e0, 512);
        check("wrap_count", press_count, 0);
        check("wrap_pops", pops - p0, 768);
        check("wrap_err", err, 0);

        // Overflow after F0 drops the pending break
        push(8'hF0);
        drain();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        check("ovf_err", err, 1);
        e0 = evq.size();
        push(8'h1C);
        drain();
        check("ovf_evts", evq.size() - e0, 1);
        check("ovf_brk", evq[e0].brk, 0);
        check("ovf_down", key_down, 1);
        check("ovf_count", press_count, 1);

        // Overflow on the same edge as an E0 decode
        push(8'hE0);
        tick(); tick();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        e0 = evq.size();
        drain();
        push(8'h2A);
        drain();
        check("race_evts", evq.size() - e0, 1);
        check("race_ev", {evq[e0].code, evq[e0].ext, evq[e0].brk}, {8'h2A, 1'b0, 1'b0});
        check("race_count", press_count, 2);

        // Reset asserted while the pop strobe is low
        push(8'h1C);
        tick();
        check("pop_low", nextdata_n, 0);
        #2 clrn = 1'b0;
        #1;
        check("arst_nextdata_n", nextdata_n, 1);
        check("arst_key_code", key_code, 8'h00);
        check("arst_down", key_down, 0);
        check("arst_count", press_count, 0);
        check("arst_err", err, 0);
        fifo.delete();
        upd();
        repeat (2) tick();
        clrn = 1'b1;
        e0 = evq.size();
        repeat (8) tick();
        check("arst_quiet", evq.size() - e0, 0);
        push(8'h2A);
        drain();
        check("arst_evts", evq.size() - e0, 1);
        check("arst_code", evq[e0].code, 8'h2A);
        check("arst_count2", press_count, 1);

        check("bad_pops", bad_pops, 0);
        check("long_pulses", long_pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
